input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Front-end conditioning stage that sits directly upstream of the binary decoder top level and feeds its button and DIP-switch inputs. Raw board buttons are synchronised, debounced and edge-detected. Each button toggles a per-digit display-enable bit. Raw DIP-switch lines are synchronised before they drive the LED and seven-segment paths.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range >= 2
NUM_BUTTONS, 4, number of push-button channels
SWITCH_WIDTH, 8, DIP-switch data width

Ports:
clockIn  input  1  system clock; all state on rising edge
resetN  input  1  synchronous active-low reset, sampled on clockIn rising edge
buttonsRaw  input  NUM_BUTTONS  asynchronous raw push-button levels, 1 = pressed
dipSwitchRaw  input  SWITCH_WIDTH  asynchronous raw DIP-switch levels
buttonsLevel  output  NUM_BUTTONS  debounced button level
buttonsPressed  output  NUM_BUTTONS  one-cycle pulse on debounced 0->1 transition
buttonsReleased  output  NUM_BUTTONS  one-cycle pulse on debounced 1->0 transition
displayEnable  output  NUM_BUTTONS  per-digit enable, toggled by each press; drives the controlButtons input downstream
dipSwitchSync  output  SWITCH_WIDTH  synchronised DIP-switch value

Behaviour:
- One clock (clockIn); reset synchronous, active-low (resetN). No asynchronous logic apart from the synchroniser first stage.
- Reset (resetN=0 at an edge), applied regardless of in-flight activity:
  - buttonsLevel=0, buttonsPressed=0, buttonsReleased=0
  - displayEnable=all ones, dipSwitchSync=0
  - all synchroniser flops = 0, all debounce counters = 0
- Synchroniser: two-flop chain per bit for buttonsRaw and dipSwitchRaw. dipSwitchSync = second stage; it reflects a raw change after exactly 2 edges. No debounce on switches.
- Debounce, per button channel i, independent counter count_i:
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - If sync2_i == buttonsLevel_i: count_i <= 0.
  - Else if count_i == DEBOUNCE_CYCLES-1: buttonsLevel_i <= sync2_i, count_i <= 0.
  - Else: count_i <= count_i + 1.
  - Counter never wraps; it is bounded by the compare above.
- Latency: a raw change held steady from before edge 0 appears on buttonsLevel after edge DEBOUNCE_CYCLES+1. Total = 2 synchroniser edges + DEBOUNCE_CYCLES mismatch edges, minus one overlap.
- Glitch rejection: any return of sync2_i to buttonsLevel_i before the count completes clears count_i. Bounces shorter than DEBOUNCE_CYCLES consecutive cycles produce no output change.
- Pulses:
  - buttonsPressed_i and buttonsReleased_i are registered and asserted for exactly the one cycle following the edge at which buttonsLevel_i changes.
  - Both are never asserted together on one channel; otherwise 0.
- Toggle: displayEnable_i inverts on the same edge that sets buttonsLevel_i 0->1. Release has no effect on it.
- Simultaneous events:
  - Channels are fully independent; multiple channels may pulse in the same cycle.
  - Reset asserted on the same edge as a debounce completion wins: reset values are loaded.
- Reset mid-count: counter cleared. After release of reset, a still-pressed button needs the full 2+DEBOUNCE_CYCLES latency again. It then yields a press pulse and toggles displayEnable from its reset value.

Test Plan:
(Bench runs with DEBOUNCE_CYCLES=4.)
- Reset: hold resetN=0 for 3 edges with random raw inputs -> buttonsLevel=0, pulses=0, displayEnable=4'b1111, dipSwitchSync=8'h00.
- Clean press: buttonsRaw=4'b0001 set before edge 0 -> buttonsLevel[0]=1 after edge 5; buttonsPressed=4'b0001 for that single cycle; displayEnable=4'b1110. Release by the same pattern -> buttonsReleased[0] single pulse, displayEnable unchanged.
- Bounce: toggle buttonsRaw[1] every 2 cycles for 20 cycles, then hold 0 -> buttonsLevel[1], pulses and displayEnable[1] unchanged throughout.
- Double press: two clean presses on button 2 -> displayEnable[2] goes 1->0->1; exactly two buttonsPressed[2] pulses.
- Simultaneous: buttonsRaw 4'b0000->4'b1010 on one edge -> buttonsPressed=4'b1010 in one cycle; displayEnable=4'b0101.
- Switch path and reset mid-count:
  - dipSwitchRaw=8'hA5 -> dipSwitchSync=8'hA5 after exactly 2 edges.
  - Pulse resetN=0 at mismatch count 2 with button 3 held -> no pulse; buttonsPressed[3] fires 5 edges after reset release.

Source files
------------

// File: rtl/input_conditioner.sv
// Button/DIP-switch front end: two-flop synchronisers, per-button debounce with press/release pulses and press-toggled display enables.
// Latency: switches 2 edges; buttons DEBOUNCE_CYCLES+2 edges from raw change to level/pulse.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_BUTTONS     = 4,
    parameter int SWITCH_WIDTH    = 8
) (
    input  logic                    clockIn,
    input  logic                    resetN,
    input  logic [NUM_BUTTONS-1:0]  buttonsRaw,
    input  logic [SWITCH_WIDTH-1:0] dipSwitchRaw,
    output logic [NUM_BUTTONS-1:0]  buttonsLevel,
    output logic [NUM_BUTTONS-1:0]  buttonsPressed,
    output logic [NUM_BUTTONS-1:0]  buttonsReleased,
    output logic [NUM_BUTTONS-1:0]  displayEnable,
    output logic [SWITCH_WIDTH-1:0] dipSwitchSync
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0]  btn_sync1;
    logic [NUM_BUTTONS-1:0]  btn_sync2;
    logic [SWITCH_WIDTH-1:0] dip_sync1;
    logic [CW-1:0]           count [NUM_BUTTONS];

    always_ff @(posedge clockIn) begin
        if (!resetN) begin
            btn_sync1       <= '0;
            btn_sync2       <= '0;
            dip_sync1       <= '0;
            dipSwitchSync   <= '0;
            buttonsLevel    <= '0;
            buttonsPressed  <= '0;
            buttonsReleased <= '0;
            displayEnable   <= '1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                count[i] <= '0;
            end
        end else begin
            btn_sync1     <= buttonsRaw;
            btn_sync2     <= btn_sync1;
            dip_sync1     <= dipSwitchRaw;
            dipSwitchSync <= dip_sync1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                buttonsPressed[i]  <= 1'b0;
                buttonsReleased[i] <= 1'b0;
                // Any return to the accepted level restarts the stability window.
                if (btn_sync2[i] == buttonsLevel[i]) begin
                    count[i] <= '0;
                end else if (count[i] == COUNT_LAST) begin
                    count[i]        <= '0;
                    buttonsLevel[i] <= btn_sync2[i];
                    if (btn_sync2[i]) begin
                        buttonsPressed[i] <= 1'b1;
                        displayEnable[i]  <= ~displayEnable[i];
                    end else begin
                        buttonsReleased[i] <= 1'b1;
                    end
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: pulse events go through an expected-event queue.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [7:0] dip_raw = '0;
    logic [3:0] lvl, prs, rls, en;
    logic [7:0] dip_sync;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] e;
        logic [3:0] l;
    } ev_t;
    ev_t exp_q[$];

    input_conditioner #(.DEBOUNCE_CYCLES(4), .NUM_BUTTONS(4), .SWITCH_WIDTH(8)) dut (
        .clockIn(clk), .resetN(rst_n), .buttonsRaw(btn_raw), .dipSwitchRaw(dip_raw),
        .buttonsLevel(lvl), .buttonsPressed(prs), .buttonsReleased(rls),
        .displayEnable(en), .dipSwitchSync(dip_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must match the oldest expected event exactly.
    always @(negedge clk) begin
        if ((prs | rls) != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d pressed=%b released=%b expected none", cyc, prs, rls);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if (ev.at !== cyc || ev.p !== prs || ev.r !== rls || ev.e !== en || ev.l !== lvl) begin
                    errors++;
                    $display("FAIL pulse_event got cyc=%0d p=%b r=%b en=%b lvl=%b expected cyc=%0d p=%b r=%b en=%b lvl=%b",
                             cyc, prs, rls, en, lvl, ev.at, ev.p, ev.r, ev.e, ev.l);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses got %0d outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drive a raw change and expect its debounced event DEBOUNCE_CYCLES+2 edges later.
    task automatic change(input logic [3:0] raw, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] e, input string name);
        btn_raw = raw;
        exp_q.push_back('{at: cyc + 6, p: p, r: r, e: e, l: raw});
        step(10);
        drain(name);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        btn_raw = '0;
        step(1);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_raw = 4'($urandom);
            dip_raw = 8'($urandom);
            step(1);
        end
        checks++; if (lvl !== 4'b0000) begin errors++; $display("FAIL reset_level got %b expected 0000", lvl); end
        checks++; if (prs !== 4'b0000) begin errors++; $display("FAIL reset_pressed got %b expected 0000", prs); end
        checks++; if (rls !== 4'b0000) begin errors++; $display("FAIL reset_released got %b expected 0000", rls); end
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL reset_enable got %b expected 1111", en); end
        checks++; if (dip_sync !== 8'h00) begin errors++; $display("FAIL reset_dip got %h expected 00", dip_sync); end
        btn_raw = '0;
        dip_raw = '0;
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_clean_press();
        change(4'b0001, 4'b0001, 4'b0000, 4'b1110, "clean_press");
        change(4'b0000, 4'b0000, 4'b0001, 4'b1110, "clean_release");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            step(2);
        end
        btn_raw[1] = 1'b0;
        step(8);
        drain("bounce");
        checks++; if (lvl !== 4'b0000) begin errors++; $display("FAIL bounce_level got %b expected 0000", lvl); end
        checks++; if (en !== 4'b1110) begin errors++; $display("FAIL bounce_enable got %b expected 1110", en); end
    endtask

    task automatic test_double_press();
        change(4'b0100, 4'b0100, 4'b0000, 4'b1010, "double_press1");
        change(4'b0000, 4'b0000, 4'b0100, 4'b1010, "double_release1");
        change(4'b0100, 4'b0100, 4'b0000, 4'b1110, "double_press2");
        change(4'b0000, 4'b0000, 4'b0100, 4'b1110, "double_release2");
    endtask

    task automatic test_simultaneous();
        apply_reset();
        change(4'b1010, 4'b1010, 4'b0000, 4'b0101, "simul_press");
        change(4'b0000, 4'b0000, 4'b1010, 4'b0101, "simul_release");
    endtask

    task automatic test_switch();
        dip_raw = 8'hA5;
        step(1);
        checks++; if (dip_sync !== 8'h00) begin errors++; $display("FAIL dip_edge1 got %h expected 00", dip_sync); end
        step(1);
        checks++; if (dip_sync !== 8'hA5) begin errors++; $display("FAIL dip_edge2 got %h expected a5", dip_sync); end
        dip_raw = 8'h3C;
        step(2);
        checks++; if (dip_sync !== 8'h3C) begin errors++; $display("FAIL dip_second got %h expected 3c", dip_sync); end
    endtask

    task automatic test_reset_mid_count();
        btn_raw = 4'b1000;
        step(4);
        rst_n = 1'b0;
        step(1);
        checks++; if (lvl !== 4'b0000) begin errors++; $display("FAIL midreset_level got %b expected 0000", lvl); end
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL midreset_enable got %b expected 1111", en); end
        rst_n = 1'b1;
        exp_q.push_back('{at: cyc + 6, p: 4'b1000, r: 4'b0000, e: 4'b0111, l: 4'b1000});
        step(5);
        checks++; if (lvl !== 4'b0000) begin errors++; $display("FAIL midreset_early got %b expected 0000", lvl); end
        step(5);
        drain("midreset_press");
        checks++; if (lvl !== 4'b1000) begin errors++; $display("FAIL midreset_final got %b expected 1000", lvl); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_double_press();
        test_simultaneous();
        test_switch();
        test_reset_mid_count();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
